// File: rtl/cpu_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_arb_pkg
// Purpose  : Shared state encoding, constants and grant helper for the
//            instruction/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_BUSY_I = 2'd1;
    localparam arb_state_t ST_BUSY_D = 2'd2;
    localparam arb_state_t ST_RESP   = 2'd3;

    localparam logic [31:0] DEAD_WORD       = 32'hDEAD_BEEF;
    localparam int          DEF_STARVE_MAX  = 4;
    localparam int          DEF_TIMEOUT_CYC = 64;

    // Data wins arbitration unless fetch is also waiting and has been starved.
    function automatic logic data_wins(input logic d_req,
                                       input logic if_req,
                                       input logic starved);
        return d_req & ~(if_req & starved);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module   : arb_starve_cnt
// Purpose  : Saturating starvation counter; clr has priority over inc.
// Revision : 1.0 - initial release
// ============================================================================
module arb_starve_cnt #(
    parameter int MAX   = 4,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign sat = (count_q == CNT_W'(MAX));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !sat) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_arbiter
// Purpose  : Arbitrates fetch and load/store ports onto one single-port memory
//            with a variable-latency req/ack handshake.
//            Optional macro CPU_MEM_ARBITER_TIMEOUT_EN enables the ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STARVE_MAX  = DEF_STARVE_MAX,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    generate
        if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
            $error("cpu_mem_arbiter: STARVE_MAX must be in 1..15");
        end
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cyc
            $error("cpu_mem_arbiter: TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              idle, busy, finish, abort;
    logic              grant_dat, grant_if;
    logic              starve_inc, starve_clr, starve_sat;
    logic [DATA_W-1:0] ret_word;

    assign idle      = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
    assign grant_dat = idle & data_wins(d_req, if_req, starve_sat);
    assign grant_if  = idle & if_req & ~grant_dat;
    assign finish    = busy & (mem_ack | abort);
    assign ret_word  = abort ? DATA_W'(DEAD_WORD) : mem_rdata;

    // A data grant only counts toward starvation when fetch was left waiting.
    assign starve_inc = grant_dat & if_req;
    assign starve_clr = grant_if | (grant_dat & ~if_req);

    arb_starve_cnt #(
        .MAX   (STARVE_MAX),
        .CNT_W (4)
    ) u_starve_cnt (
        .clk (clock),
        .rst (reset),
        .inc (starve_inc),
        .clr (starve_clr),
        .sat (starve_sat)
    );

`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;

    // Abort in the TIMEOUT_CYC-th busy cycle so the ack lands TIMEOUT_CYC after mem_req.
    assign abort = busy & ~mem_ack & (wcnt_q == WCNT_W'(TIMEOUT_CYC - 1));
    assign err   = err_q;

    always_comb begin
        wcnt_d = wcnt_q;
        err_d  = abort;
        if (grant_dat || grant_if) begin
            wcnt_d = '0;
        end else if (busy) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_dat) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr & WORD_MASK;
                    mem_wdata_d = d_wdata;
                end else if (grant_if) begin
                    state_d     = ST_BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr & WORD_MASK;
                    mem_wdata_d = '0;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (finish) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == ST_BUSY_I) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = ret_word;
                    end else begin
                        d_ack_d = 1'b1;
                        // Completed stores keep the previous load data.
                        if (!mem_we_q || abort) begin
                            d_rdata_d = ret_word;
                        end
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign d_stall   = d_req & ~d_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_arbiter
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            against a word-memory scoreboard and a starvation-rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int TMO  = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_stall;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] memarr [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];
    bit          mem_auto   = 1'b0;
    bit          rand_waits = 1'b0;
    int          mem_waits  = 0;
    int          mwait      = 0;

    always #5 clock = ~clock;

    cpu_mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_MAX  (SMAX),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return memarr.exists(a) ? memarr[a] : (a ^ 32'hA5A5_0000);
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : (a ^ 32'hA5A5_0000);
    endfunction

    // One clock; the memory model answers after a configurable number of wait cycles.
    task automatic step();
        if (mem_auto && mem_req && mem_ack && mem_we) memarr[mem_addr] = mem_wdata;
        @(posedge clock);
        #1;
        if (mem_auto) begin
            if (mem_req) begin
                if (mwait == 0 && rand_waits) mem_waits = int'($urandom_range(0, 3));
                mem_ack   = (mwait >= mem_waits);
                mem_rdata = mem_ack ? mem_rd(mem_addr) : $urandom;
                mwait++;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                mwait     = 0;
            end
        end
    endtask

    task automatic do_reset();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [4+AW+3*DW:0] outs;
        mem_auto = 1'b0; mem_ack = 1'b0;
        do_reset();
        outs = {mem_req, mem_we, if_ack, d_ack, err, mem_addr, mem_wdata, if_rdata, d_rdata};
        vectors++;
        if (outs !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        step();
        vectors++;
        if ({mem_req, if_stall, d_stall} !== 3'b000) begin
            miscompares++; $display("FAIL reset_idle: got req/stalls %b want 000", {mem_req, if_stall, d_stall});
        end
    endtask

    task automatic test_single_fetch();
        memarr[32'h10] = 32'h2008_0005;
        mem_auto = 1'b1; rand_waits = 1'b0; mem_waits = 0;
        if_req = 1'b1; if_addr = 32'h0000_0013;
        #1;
        vectors++;
        if (if_stall !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_c0: got %b want 1", if_stall); end
        step();
        vectors++;
        if ({mem_req, mem_we, if_ack, if_stall} !== 4'b1001) begin
            miscompares++; $display("FAIL fetch_c1_ctrl: got req/we/ack/stall %b want 1001", {mem_req, mem_we, if_ack, if_stall});
        end
        vectors++;
        if (mem_addr !== 32'h0000_0010) begin miscompares++; $display("FAIL fetch_c1_addr: got %h want 00000010", mem_addr); end
        step();
        vectors++;
        if ({if_ack, if_stall, mem_req} !== 3'b100) begin
            miscompares++; $display("FAIL fetch_c2_ctrl: got ack/stall/req %b want 100", {if_ack, if_stall, mem_req});
        end
        vectors++;
        if (if_rdata !== 32'h2008_0005) begin miscompares++; $display("FAIL fetch_c2_rdata: got %h want 20080005", if_rdata); end
        if_req = 1'b0;
        step();
        vectors++;
        if (if_ack !== 1'b0 || if_rdata !== 32'h2008_0005) begin
            miscompares++; $display("FAIL fetch_hold: got ack %b rdata %h want 0 20080005", if_ack, if_rdata);
        end
    endtask

    task automatic test_store_load();
        int n = 0;
        int guard = 0;
        bit we_bad = 1'b0;
        mem_auto = 1'b1; rand_waits = 1'b0; mem_waits = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        step();
        while (d_ack !== 1'b1 && guard < 20) begin
            if (mem_req === 1'b1) begin n++; if (mem_we !== 1'b1) we_bad = 1'b1; end
            step();
            guard++;
        end
        vectors++;
        if (guard >= 20) begin miscompares++; $display("FAIL store_ack_timeout: got no d_ack want d_ack"); end
        vectors++;
        if (n != 4 || we_bad) begin miscompares++; $display("FAIL store_mem_req_len: got %0d cycles we_bad %0d want 4 0", n, we_bad); end
        d_req = 1'b0; d_we = 1'b0;
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        guard = 0;
        step();
        while (d_ack !== 1'b1 && guard < 20) begin step(); guard++; end
        vectors++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h1234_5678) begin
            miscompares++; $display("FAIL load_after_store: got ack %b data %h want 1 12345678", d_ack, d_rdata);
        end
        d_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_contention();
        string got = "";
        string exp = "";
        int streak = 0;
        int grants = 0;
        int guard = 0;
        bit prev_req = 1'b0;
        do_reset();
        mem_auto = 1'b1; rand_waits = 1'b0; mem_waits = 0;
        for (int k = 0; k < 10; k++) begin
            if (streak == SMAX) begin exp = {exp, "I"}; streak = 0; end
            else begin exp = {exp, "D"}; streak++; end
        end
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        while (grants < 10 && guard < 200) begin
            step();
            guard++;
            if (mem_req === 1'b1 && !prev_req) begin
                grants++;
                if (mem_addr === 32'h100) got = {got, "I"};
                else if (mem_addr === 32'h200) got = {got, "D"};
                else got = {got, "X"};
            end
            prev_req = (mem_req === 1'b1);
        end
        vectors++;
        if (got != exp) begin miscompares++; $display("FAIL contention_order: got %s want %s", got, exp); end
        if_req = 1'b0; d_req = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_reset_mid();
        mem_auto = 1'b0; mem_ack = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        step();
        vectors++;
        if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy: got mem_req %b want 1", mem_req); end
        step();
        reset = 1'b1;
        step();
        vectors++;
        if ({mem_req, d_ack} !== 2'b00) begin
            miscompares++; $display("FAIL rstmid_abort: got req/ack %b want 00", {mem_req, d_ack});
        end
        reset = 1'b0; d_req = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        step();
        mem_ack = 1'b0;
        vectors++;
        if ({mem_req, d_ack, if_ack} !== 3'b000) begin
            miscompares++; $display("FAIL rstmid_late_ack: got req/dack/iack %b want 000", {mem_req, d_ack, if_ack});
        end
        step();
        vectors++;
        if (d_ack !== 1'b0 || d_rdata !== 32'h0) begin
            miscompares++; $display("FAIL rstmid_rdata: got ack %b data %h want 0 00000000", d_ack, d_rdata);
        end
    endtask

    task automatic test_spurious_ack();
        logic [31:0] ir0, dr0;
        bit bad = 1'b0;
        mem_auto = 1'b0;
        ir0 = if_rdata; dr0 = d_rdata;
        for (int k = 0; k < 6; k++) begin
            mem_ack = (k != 2); mem_rdata = $urandom;
            step();
            if ({if_ack, d_ack, mem_req} !== 3'b000 || if_rdata !== ir0 || d_rdata !== dr0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL spurious_ack: got ack/req or rdata change want none"); end
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        if_req = 1'b1; if_addr = 32'h24;
        step();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h24) begin
            miscompares++; $display("FAIL spurious_then_grant: got req %b addr %h want 1 00000024", mem_req, mem_addr);
        end
        step();
        vectors++;
        if (if_ack !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin
            miscompares++; $display("FAIL spurious_then_ack: got ack %b data %h want 1 0badf00d", if_ack, if_rdata);
        end
        if_req = 1'b0;
        step();
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        mem_auto = 1'b0; mem_ack = 1'b0;
        do_reset();
        if_req = 1'b1; if_addr = 32'h30;
`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
        begin
            int cnt = 0;
            step();
            vectors++;
            if (mem_req !== 1'b1) begin miscompares++; $display("FAIL timeout_req: got %b want 1", mem_req); end
            while (if_ack !== 1'b1 && cnt < 40) begin step(); cnt++; end
            vectors++;
            if (cnt != TMO) begin miscompares++; $display("FAIL timeout_latency: got %0d want %0d", cnt, TMO); end
            vectors++;
            if ({if_ack, err, mem_req} !== 3'b110 || if_rdata !== 32'hDEAD_BEEF) begin
                miscompares++; $display("FAIL timeout_abort: got ack/err/req %b data %h want 110 deadbeef", {if_ack, err, mem_req}, if_rdata);
            end
            if_req = 1'b0;
            step();
            vectors++;
            if (err !== 1'b0) begin miscompares++; $display("FAIL timeout_err_pulse: got %b want 0", err); end
        end
`else
        begin
            int bad = 0;
            for (int k = 0; k < 100; k++) begin
                step();
                if (if_stall !== 1'b1 || if_ack !== 1'b0 || err !== 1'b0) bad++;
            end
            vectors++;
            if (bad != 0) begin miscompares++; $display("FAIL no_timeout_wait: got %0d bad cycles want 0", bad); end
        end
`endif
        do_reset();
        step();
    endtask

    task automatic test_random_traffic();
        bit          i_pend = 1'b0, d_pend = 1'b0, prev_mreq = 1'b0;
        int          streak = 0;
        int          owner = 0;
        int          win;
        logic [31:0] a;
        do_reset();
        memarr.delete(); shadow.delete();
        mem_auto = 1'b1; rand_waits = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            step();
            vectors++;
            if (if_stall !== (if_req & ~if_ack) || d_stall !== (d_req & ~d_ack)) begin
                miscompares++; $display("FAIL rnd_stall c%0d: got %b%b want %b%b", c, if_stall, d_stall, if_req & ~if_ack, d_req & ~d_ack);
            end
            if (mem_req === 1'b1 && !prev_mreq) begin
                win = (d_req && !(if_req && streak == SMAX)) ? 2 : 1;
                streak = (win == 2 && if_req) ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
                owner = win;
                vectors++;
                if (win == 2) begin
                    if (mem_addr !== align(d_addr) || mem_we !== d_we || (d_we && mem_wdata !== d_wdata)) begin
                        miscompares++; $display("FAIL rnd_grant_d c%0d: got %h/%b/%h want %h/%b/%h", c, mem_addr, mem_we, mem_wdata, align(d_addr), d_we, d_wdata);
                    end
                end else if (mem_addr !== align(if_addr) || mem_we !== 1'b0) begin
                    miscompares++; $display("FAIL rnd_grant_i c%0d: got %h/%b want %h/0", c, mem_addr, mem_we, align(if_addr));
                end
            end
            if (if_ack === 1'b1) begin
                vectors++;
                if (owner != 1 || if_rdata !== shadow_rd(align(if_addr))) begin
                    miscompares++; $display("FAIL rnd_if_ack c%0d: got owner %0d data %h want 1 %h", c, owner, if_rdata, shadow_rd(align(if_addr)));
                end
                i_pend = 1'b0; owner = 0;
            end
            if (d_ack === 1'b1) begin
                vectors++;
                if (owner != 2 || (!d_we && d_rdata !== shadow_rd(align(d_addr)))) begin
                    miscompares++; $display("FAIL rnd_d_ack c%0d: got owner %0d data %h want 2 %h", c, owner, d_rdata, shadow_rd(align(d_addr)));
                end
                if (d_we) shadow[align(d_addr)] = d_wdata;
                d_pend = 1'b0; owner = 0;
            end
            prev_mreq = (mem_req === 1'b1);
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                if_addr = a;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1;
                a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                d_addr = a; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end
            if_req = i_pend;
            d_req = d_pend;
        end
        if_req = 1'b0; d_req = 1'b0;
        mem_auto = 1'b0; mem_ack = 1'b0;
        do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_reset_mid();
        test_spurious_ack();
        test_timeout();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and its data (lw/sw) port.
- Arbitrates each access, sequences a variable-latency memory handshake and returns read data to the winner.
- Provides per-port stall indications so the pipeline can hold IF or MEM stages until their access completes.
- Sits between the 5-stage CPU core and the memory model / top-level memory.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits.
- STARVE_MAX, 4, maximum consecutive data grants while fetch is waiting; the next arbitration then goes to fetch. Legal range 1..15.
- TIMEOUT_CYC, 64, mem_ack wait limit in cycles. Used only with the optional feature.

Ports:
- clock  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  DATA_W  fetched instruction word.
- if_stall  out  1  if_req & ~if_ack (combinational).
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  load data; valid while d_ack is high.
- d_stall  out  1  d_req & ~d_ack (combinational).
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; sampled only while mem_req is high.
- mem_rdata  in  DATA_W  read data; valid with mem_ack.
- err  out  1  timeout pulse (optional feature).

Behaviour:
- Reset values: state IDLE. mem_req, mem_we, if_ack, d_ack and err are 0. mem_addr, mem_wdata, if_rdata and d_rdata are 0. Starvation counter fcnt is 0.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, d_req only: go to BUSY_D.
- IDLE, if_req only: go to BUSY_I.
- IDLE, both requests: if fcnt == STARVE_MAX, grant fetch, otherwise grant data.
- On a grant, register mem_addr, mem_we (d_we for data, 0 for fetch) and mem_wdata, and set mem_req = 1.
- BUSY_x: hold mem_req and all mem_* outputs stable. On a cycle where mem_ack = 1:
  - register mem_rdata into x_rdata (write returns the previous d_rdata value, don't-care);
  - pulse x_ack on the next cycle;
  - drop mem_req on the next cycle;
  - go to RESP.
- RESP: lasts exactly one cycle, then IDLE. The acked requester may drop or re-present its request. Requests are sampled only in IDLE.
- Latency with zero-wait memory (mem_ack combinationally high):
  - req seen in cycle 0;
  - mem_req in cycle 1;
  - x_ack in cycle 2;
  - next grant in cycle 3 or later.
  - Each memory wait cycle adds 1.
- fcnt rules:
  - increments (saturating at STARVE_MAX) on each data grant made while if_req = 1;
  - clears on any fetch grant;
  - clears on a data grant made while if_req = 0.
- mem_ack while in IDLE or RESP is ignored.
- Requester address or data changes while in BUSY are ignored; the latched values are used.
- Reset mid-transaction: next cycle, state = IDLE and mem_req = 0. No x_ack is issued. A late mem_ack is ignored.
- if_rdata and d_rdata hold their values until the next completion for that port.

Optional Feature:
- Macro: CPU_MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - A wait counter runs in BUSY_x.
  - When it reaches TIMEOUT_CYC without mem_ack, the access aborts: mem_req drops, x_ack pulses with x_rdata = 32'hDEAD_BEEF, err pulses for 1 cycle together with x_ack, and the FSM goes to RESP.
  - The counter clears on every grant.
- Not defined: no counter, err is tied to 0, and the FSM waits indefinitely for mem_ack.

Decomposition:
- Package cpu_mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_I, BUSY_D, RESP);
  - the DEAD_WORD constant 32'hDEAD_BEEF;
  - the default STARVE_MAX and TIMEOUT_CYC.
- One sub-module, arb_starve_cnt: saturating counter with inc, clr and sat outputs, reusable for further requesters.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Single fetch, zero-wait memory: if_addr = 0x0000_0013, mem_rdata = 0x2008_0005. Expect mem_addr = 0x0000_0010 in cycle 1, if_ack with if_rdata = 0x2008_0005 in cycle 2, if_stall high in cycles 0-1.
- Store then load with 3 wait cycles: sw d_addr = 0x40, d_wdata = 0x1234_5678 gives mem_we = 1 with mem_req held 4 cycles, then d_ack. A following lw to 0x40 returns 0x1234_5678.
- Contention: if_req and d_req both held continuously, STARVE_MAX = 4. Grant order is D,D,D,D,I,D,D,D,D,I.
- Reset asserted during BUSY_D: mem_req = 0 on the next cycle, no d_ack, and a mem_ack two cycles later produces no ack.
- Spurious mem_ack pulses in IDLE: no x_ack and no state change.
- With CPU_MEM_ARBITER_TIMEOUT_EN and TIMEOUT_CYC = 8: fetch with mem_ack never asserted gives if_ack, err and if_rdata = 0xDEAD_BEEF 8 cycles after mem_req rose. Without the macro, the bench sees if_stall high indefinitely.
